// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and control codes for the execute-stage divider
//
// Purpose: state encoding of the div_unit FSM and the ALU control codes that
// the E-stage decode compares against to raise start_i for DIV/DIVU.
// Ports: none (package).

package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // ALU control codes shared with the E-stage decode.
  localparam logic [4:0] DIV_CONTROL  = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL = 5'b11011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_DIVZERO = 2'd2,
    ST_DONE    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit restoring divider for DIV/DIVU
//
// Purpose: computes quotient and remainder over 32 restoring iterations for
// HI/LO writeback; ready_o feeds the hazard unit's divider stall.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   signed_div_i  1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       DIV/DIVU present in E
//   annul_i       abandon current operation (exception flush)
//   result_o      {remainder, quotient}; [63:32] -> HI, [31:0] -> LO
//   ready_o       one-cycle pulse when result_o is valid

module div_unit
  import div_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   signed_div_i,
  input  logic [DIV_WIDTH-1:0]   opdata1_i,
  input  logic [DIV_WIDTH-1:0]   opdata2_i,
  input  logic                   start_i,
  input  logic                   annul_i,
  output logic [2*DIV_WIDTH-1:0] result_o,
  output logic                   ready_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [64:0] part_q, part_d;     // {partial remainder (33b), dividend/quotient (32b)}
  logic [31:0] dvsr_q, dvsr_d;     // |divisor|
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [65:0] shifted;
  logic [33:0] trial;
  logic [64:0] step;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  // One restoring iteration on the current partial register.
  always_comb begin
    shifted = {part_q, 1'b0};
    trial   = shifted[65:32] - {2'b00, dvsr_q};
    if (trial[33]) begin
      step = shifted[64:0];
    end else begin
      step = {trial[32:0], shifted[31:1], 1'b1};
    end
    quot_mag = step[31:0];
    rem_mag  = step[63:32];
  end

  // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
  always_comb begin
    a_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    b_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    part_d     = part_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d  = signed_div_i && opdata1_i[31];
          if (opdata2_i == 32'd0) begin
            state_d = ST_DIVZERO;
          end else begin
            dvsr_d  = b_abs;
            part_d  = {33'd0, a_abs};
            cnt_d   = 5'd0;
            state_d = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        part_d = step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // Sign fix-up folded into the last step so result_o is registered in DONE.
          result_d = {neg_rem_q  ? (~rem_mag  + 32'd1) : rem_mag,
                      neg_quot_q ? (~quot_mag + 32'd1) : quot_mag};
          ready_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DIVZERO: begin
        result_d = 64'd0;
        ready_d  = 1'b1;
        state_d  = ST_DONE;
      end

      ST_DONE: begin
        // start_i is still high for the same instruction; it is not re-sampled here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush wins over everything, including a same-cycle start_i in IDLE.
    if (annul_i) begin
      state_d  = ST_IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 5'd0;
      part_q     <= 65'd0;
      dvsr_q     <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      part_q     <= part_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start at edge 0 (posedge after setup), sample each cycle at the negedge.
  // Operands are corrupted in cycle 2 to show they were latched.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int          first;
    int          pulses;
    logic [63:0] res;
    first  = -1;
    pulses = 0;
    res    = '0;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat + 4; cyc++) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (first < 0) begin
          first   = cyc;
          res     = result_o;
          start_i = 1'b0;
        end
      end
      if (cyc == 2 && first < 0) begin
        opdata1_i    = ~a;
        opdata2_i    = 32'd0;
        signed_div_i = ~sgn;
      end
    end
    start_i = 1'b0;
    check({name, " ready cycle"}, 64'(first), 64'(lat));
    check({name, " ready pulses"}, 64'(pulses), 64'd1);
    check({name, " result"}, res, exp);
  endtask

  initial begin
    int          pulses;
    int          c1;
    int          c2;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] last_exp;

    vecs[0] = '{"divu 100/7",       1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                 33};
    vecs[1] = '{"div -7/2",         1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD},    33};
    vecs[2] = '{"div min/-1",       1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0, 32'h80000000},           33};
    vecs[3] = '{"divu max/1",       1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0, 32'hFFFFFFFF},           33};
    vecs[4] = '{"divu 5/0",         1'b0, 32'd5,         32'd0,         64'd0,                           2};
    vecs[5] = '{"div 7/-2",         1'b1, 32'd7,         32'hFFFFFFFE,  {32'd1, 32'hFFFFFFFD},           33};
    vecs[6] = '{"div min/min",      1'b1, 32'h80000000,  32'h80000000,  {32'd0, 32'd1},                  33};
    vecs[7] = '{"divu 3/10",        1'b0, 32'd3,         32'd10,        {32'd3, 32'd0},                  33};
    vecs[8] = '{"div 0/0",          1'b1, 32'd0,         32'd0,         64'd0,                           2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset result_o", result_o, 64'd0);
    check("reset ready_o", {63'd0, ready_o}, 64'd0);
    rst = 1'b0;

    last_exp = '0;
    for (int i = 0; i < 9; i++) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      last_exp = vecs[i].exp;
    end

    // Annul in cycle 10; annul and start overlap for two cycles, including IDLE.
    pulses = 0;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (ready_o) pulses++;
      if (cyc == 1) start_i = 1'b0;
      if (cyc == 10) begin
        annul_i = 1'b1;
        start_i = 1'b1;
      end
      if (cyc == 12) begin
        annul_i = 1'b0;
        start_i = 1'b0;
      end
    end
    check("annul no ready", 64'(pulses), 64'd0);
    check("annul result held", result_o, last_exp);
    run_div("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Async reset in cycle 20 of a running divide.
    pulses = 0;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    #1 rst = 1'b1;
    #1;
    check("rst result_o immediate", result_o, 64'd0);
    check("rst ready_o immediate", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst     = 1'b0;
    start_i = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ready_o) pulses++;
    end
    check("rst no ready", 64'(pulses), 64'd0);
    check("rst result stays 0", result_o, 64'd0);

    // Back-to-back: start held through DONE, next operands enter at the DONE edge.
    pulses = 0;
    c1 = -1;
    c2 = -1;
    r1 = '0;
    r2 = '0;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 72; cyc++) begin
      @(negedge clk);
      if (ready_o) begin
        pulses++;
        if (c1 < 0) begin
          c1 = cyc;
          r1 = result_o;
          opdata1_i = 32'd51;
        end else if (c2 < 0) begin
          c2 = cyc;
          r2 = result_o;
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check("b2b pulses", 64'(pulses), 64'd2);
    check("b2b first cycle", 64'(c1), 64'd33);
    check("b2b first result", r1, {32'd0, 32'd10});
    check("b2b second cycle", 64'(c2), 64'd67);
    check("b2b second result", r2, {32'd1, 32'd10});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider in the execute stage of the 5-stage MIPS pipeline. Executes DIV/DIVU over 32 restoring-division iterations and returns quotient and remainder for HI/LO writeback. Its `ready_o` is the `ready_oE` input the hazard unit uses to build `stall_divE`: while a DIV/DIVU sits in E and `ready_o` is low, F/D/E stall. `annul_i` is driven from the exception flush so an in-flight division is abandoned when the pipeline is flushed.

## Interface
- No parameters; the data width is fixed at 32.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `signed_div_i`  in  1  1 selects DIV (signed), 0 selects DIVU; sampled with `start_i`.
- `opdata1_i`  in  32  dividend (forwarded rs value in E).
- `opdata2_i`  in  32  divisor (forwarded rt value in E).
- `start_i`  in  1  high while a DIV/DIVU occupies E (alucontrolE decode).
- `annul_i`  in  1  abort current operation (exception flush).
- `result_o`  out  64  {remainder, quotient}; [63:32] goes to HI, [31:0] goes to LO.
- `ready_o`  out  1  result valid; high for exactly one cycle per completed division.

## Operation
- States: IDLE, BUSY, DIVZERO, DONE. All outputs are registered.
- Reset: state IDLE, `result_o` = 0, `ready_o` = 0, iteration counter = 0.
- IDLE: if `start_i` and not `annul_i`, latch the operands and `signed_div_i`.
  - If the divisor is 0, go to DIVZERO.
  - Otherwise, for signed operations take the absolute value of each negative operand, load the 65-bit partial register {33'b0, |dividend|}, clear the counter, and go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift the partial register left by 1 and trial-subtract |divisor| from bits [64:32].
  - If the result is non-negative, keep the difference and set quotient bit 1; otherwise restore and set 0.
  - After the 32nd step (counter == 31), go to DONE.
- DIVZERO: go to DONE with quotient = 0 and remainder = 0; no exception is raised.
- DONE: drive `result_o` and `ready_o` = 1 for this one cycle, then return to IDLE unconditionally.
  - `start_i` is still high in DONE because the same instruction is in E; it is ignored.
- Sign fix-up, applied on the BUSY→DONE transition when signed:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
- Arithmetic rules:
  - Two's-complement wrap applies: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - |0x80000000| is handled as unsigned 0x80000000.
- Operand changes and `start_i` toggles during BUSY/DIVZERO are ignored, because the operands are latched.
- `annul_i` in any state: go to IDLE next cycle with `ready_o` = 0. `result_o` holds its last value. `annul_i` has priority over `start_i` in the same cycle.
- `result_o` holds its value after DONE until the next DONE.

## Timing
- `start_i` is sampled high in IDLE at edge 0. BUSY covers cycles 1–32, and DONE with `ready_o` = 1 falls in cycle 33. The pipeline advances at the edge ending cycle 33.
- Divide by zero: DIVZERO in cycle 1, DONE with `ready_o` = 1 in cycle 2.
- Back-to-back divides: if a new DIV enters E at the edge ending DONE, IDLE samples `start_i` in the next cycle. There is no dead cycle beyond that IDLE cycle.
- Asynchronous `rst` mid-operation forces IDLE immediately and clears `ready_o`; no result is produced.

## Structure
- State encodings (2-bit) and `DIV_CONTROL`/`DIVU_CONTROL` live in the shared defines header with the other ALU control codes. The E-stage `start_i` decode uses these same codes.
- Single module; no sub-module. Negation and absolute value are inline expressions.

## Test plan
- DIVU 100 / 7, start at edge 0: `ready_o` high only in cycle 33, `result_o` = {32'd2, 32'd14}.
- DIV 0xFFFFFFF9 (-7) / 2: `result_o` = {0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3).
- DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}; DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- DIVU 5 / 0: `ready_o` in cycle 2, `result_o` = 0.
- Abort paths:
  - `annul_i` at cycle 10 of a DIVU: `ready_o` never rises and the state returns to IDLE. A following start of 9 / 3 completes in 33 cycles with {0, 3}.
  - Async `rst` pulse at cycle 20: outputs 0 at once, no `ready_o`.
- Back-to-back DIVU 50/5 then 51/5, with `start_i` held through DONE: two single-cycle `ready_o` pulses, results {0, 10} then {1, 10}.
